shape_processor_engine: RTL and testbench

- Parametrised successor to the fixed-function shape processor.
- Holds the CTRL SFR (SHAPE/OPERATION) with WARL legality filtering.
- Executes the selected operation on latched side lengths through a start/busy/done FSM, with an optional serial shift-add multiplier for AREA.
- Sits behind the SFR bus decoder; the side-length inputs come from the operand SFRs.

---
 rtl/shape_processor_engine.sv | 146 ++++++++++++++
 tb/tb_shape_processor_engine.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shape_processor_engine.sv
// CTRL SFR (SHAPE/OPERATION, WARL-filtered) plus start/busy/done engine for shape arithmetic on latched sides.
// Latency: done 2 cycles after start; serial AREA takes SIDE_W+1 cycles. Back-to-back starts are allowed once busy has dropped.
// Backpressure: start is ignored while busy; CTRL writes while busy are dropped and raise sticky cfg_err.
module shape_processor_engine #(
    parameter int SIDE_W     = 8,
    parameter int SERIAL_MUL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_we,
    input  logic [31:0]           ctrl_wdata,
    output logic [31:0]           ctrl_rdata,
    output logic                  cfg_err,
    input  logic                  cfg_err_clr,
    input  logic [SIDE_W-1:0]     side_a,
    input  logic [SIDE_W-1:0]     side_b,
    input  logic [SIDE_W-1:0]     side_c,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*SIDE_W-1:0]   result
);
    localparam int RES_W = 2 * SIDE_W;
    localparam int CNT_W = $clog2(SIDE_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIDE_W - 1);

    localparam logic [1:0] SH_RECT = 2'b01;
    localparam logic [1:0] SH_TRI  = 2'b10;
    localparam logic [4:0] OP_PERIM = 5'b00000;
    localparam logic [4:0] OP_AREA  = 5'b00001;
    localparam logic [4:0] OP_SQ    = 5'b01000;
    localparam logic [4:0] OP_EQ    = 5'b10000;
    localparam logic [4:0] OP_ISO   = 5'b10001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [1:0]          shape, lat_shape;
    logic [4:0]          op, lat_op;
    logic [SIDE_W-1:0]   lat_a, lat_b, lat_c;
    logic [RES_W-1:0]    acc, mcand, acc_nxt, prod, op_result;
    logic [SIDE_W-1:0]   mplier;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          wr_shape;
    logic [4:0]          wr_op;
    logic                wr_legal, wr_ok, serial_area;
    logic [RES_W-1:0]    ea, eb, ec;
    logic                unused_rsvd;

    assign wr_shape    = ctrl_wdata[17:16];
    assign wr_op       = ctrl_wdata[4:0];
    assign unused_rsvd = ^{ctrl_wdata[31:18], ctrl_wdata[15:5]};
    assign ctrl_rdata  = {14'd0, shape, 11'd0, op};

    always_comb begin
        wr_legal = 1'b0;
        case (wr_op)
            OP_PERIM, OP_AREA: wr_legal = (wr_shape == SH_RECT) || (wr_shape == SH_TRI);
            OP_SQ:             wr_legal = (wr_shape == SH_RECT);
            OP_EQ, OP_ISO:     wr_legal = (wr_shape == SH_TRI);
            default:           wr_legal = 1'b0;
        endcase
    end

    assign wr_ok       = (state == IDLE) && wr_legal;
    assign serial_area = (SERIAL_MUL != 0) && (lat_op == OP_AREA);

    assign ea      = RES_W'(lat_a);
    assign eb      = RES_W'(lat_b);
    assign ec      = RES_W'(lat_c);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    // In serial mode the product is only consumed on the final CALC cycle, where acc_nxt is complete.
    assign prod    = (SERIAL_MUL != 0) ? acc_nxt : ea * eb;

    always_comb begin
        op_result = '0;
        case (lat_op)
            OP_PERIM: op_result = (lat_shape == SH_RECT) ? (ea + eb) << 1 : ea + eb + ec;
            OP_AREA:  op_result = (lat_shape == SH_RECT) ? prod : prod >> 1;
            OP_SQ:    op_result = RES_W'(lat_a == lat_b);
            OP_EQ:    op_result = RES_W'((lat_a == lat_b) && (lat_b == lat_c));
            OP_ISO:   op_result = RES_W'((lat_a == lat_b) || (lat_b == lat_c) || (lat_a == lat_c));
            default:  op_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shape     <= SH_RECT;
            op        <= OP_PERIM;
            lat_shape <= SH_RECT;
            lat_op    <= OP_PERIM;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_c     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            if (ctrl_we && wr_ok) begin
                shape <= wr_shape;
                op    <= wr_op;
            end
            // A rejected write in the same cycle as a clear leaves the flag set.
            cfg_err <= (ctrl_we && !wr_ok) || (cfg_err && !cfg_err_clr);

            case (state)
                IDLE: if (start) begin
                    lat_shape <= shape;
                    lat_op    <= op;
                    lat_a     <= side_a;
                    lat_b     <= side_b;
                    lat_c     <= side_c;
                    acc       <= '0;
                    mcand     <= RES_W'(side_a);
                    mplier    <= side_b;
                    cnt       <= '0;
                    busy      <= 1'b1;
                    state     <= CALC;
                end
                CALC: if (serial_area && cnt != LAST) begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end else begin
                    result <= op_result;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shape_processor_engine.sv
// Directed bench for shape_processor_engine (SIDE_W=8, SERIAL_MUL=1) with hand-computed expectations.
module tb_shape_processor_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_we;
    logic [31:0] ctrl_wdata;
    logic [31:0] ctrl_rdata;
    logic        cfg_err;
    logic        cfg_err_clr;
    logic [7:0]  side_a, side_b, side_c;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    shape_processor_engine #(.SIDE_W(8), .SERIAL_MUL(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
        .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr),
        .side_a(side_a), .side_b(side_b), .side_c(side_c),
        .start(start), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        ctrl_we    = 1'b1;
        ctrl_wdata = d;
        tick();
        ctrl_we    = 1'b0;
    endtask

    task automatic clr_err();
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
    endtask

    // Start edge is consumed here; sides are scrambled afterwards to prove they were latched.
    task automatic go(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        side_a = a; side_b = b; side_c = c;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        side_a = 8'hA5; side_b = 8'h3C; side_c = 8'h81;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp, input int k);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, "_busy_calc"}, {31'd0, busy}, 32'd1);
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, k);
        chk({tag, "_res"}, {16'd0, result}, exp);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; ctrl_we = 1'b0; ctrl_wdata = '0; cfg_err_clr = 1'b0;
        side_a = '0; side_b = '0; side_c = '0; start = 1'b0;
        tick(); tick();
        chk("rst_rdata", ctrl_rdata, 32'h0001_0000);
        chk("rst_state", {13'd0, busy, done, cfg_err, result}, 32'd0);
        rst_n = 1'b1;
        tick();

        wr(32'h0001_0008);
        chk("wr_sq_rdata", ctrl_rdata, 32'h0001_0008);
        chk("wr_sq_err", {31'd0, cfg_err}, 32'd0);
        wr(32'h0002_0008);
        chk("wr_trisq_rdata", ctrl_rdata, 32'h0001_0008);
        chk("wr_trisq_err", {31'd0, cfg_err}, 32'd1);
        clr_err();
        chk("clr_err", {31'd0, cfg_err}, 32'd0);
        wr(32'h0003_0000);
        chk("wr_badshape_rdata", ctrl_rdata, 32'h0001_0008);
        chk("wr_badshape_err", {31'd0, cfg_err}, 32'd1);
        cfg_err_clr = 1'b1;
        wr(32'h0000_0000);
        cfg_err_clr = 1'b0;
        chk("set_beats_clr", {31'd0, cfg_err}, 32'd1);
        clr_err();
        wr(32'hFFFD_FFE1);
        chk("wr_rsvd_rdata", ctrl_rdata, 32'h0001_0001);
        chk("wr_rsvd_err", {31'd0, cfg_err}, 32'd0);

        go(8'd255, 8'd255, 8'd0);
        wait_done("rect_area", 32'd65025, 8);
        wr(32'h0002_0001);
        go(8'd7, 8'd5, 8'd0);
        wait_done("tri_area", 32'd17, 8);

        wr(32'h0002_0000);
        go(8'd3, 8'd4, 8'd5);
        wait_done("tri_perim", 32'd12, 1);
        wr(32'h0001_0000);
        go(8'd255, 8'd255, 8'd0);
        wait_done("rect_perim", 32'd1020, 1);

        wr(32'h0002_0011);
        go(8'd5, 8'd7, 8'd5);
        wait_done("iso_yes", 32'd1, 1);
        go(8'd3, 8'd4, 8'd5);
        wait_done("iso_no", 32'd0, 1);
        wr(32'h0002_0010);
        go(8'd6, 8'd6, 8'd6);
        wait_done("equi", 32'd1, 1);
        go(8'd6, 8'd6, 8'd7);
        wait_done("equi_no", 32'd0, 1);
        wr(32'h0001_0008);
        go(8'd9, 8'd9, 8'd0);
        wait_done("square", 32'd1, 1);

        // Start with a same-cycle legal write: RECT PERIMETER runs, CTRL shows TRI PERIMETER.
        wr(32'h0001_0000);
        ctrl_we = 1'b1; ctrl_wdata = 32'h0002_0000;
        go(8'd3, 8'd4, 8'd5);
        ctrl_we = 1'b0;
        chk("samecyc_rdata", ctrl_rdata, 32'h0002_0000);
        wait_done("samecyc", 32'd14, 1);

        // Write and start while a serial AREA is in flight.
        wr(32'h0001_0001);
        go(8'd10, 8'd20, 8'd0);
        tick(); tick();
        ctrl_we = 1'b1; ctrl_wdata = 32'h0001_0000;
        start = 1'b1; side_a = 8'd1; side_b = 8'd1;
        tick();
        ctrl_we = 1'b0; start = 1'b0;
        chk("busywr_rdata", ctrl_rdata, 32'h0001_0001);
        chk("busywr_err", {31'd0, cfg_err}, 32'd1);
        wait_done("busy_area", 32'd200, 5);
        clr_err();

        // Reset in the middle of a serial AREA.
        go(8'd255, 8'd255, 8'd0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", ctrl_rdata, 32'h0001_0000);
        chk("midrst_state", {13'd0, busy, done, cfg_err, result}, 32'd0);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("midrst_nodone", pulses, 0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
